// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache-to-memory arbiter.
// Holds the FSM state set, the client ids and the line/beat geometry helpers.
package cache_mem_pkg;

  localparam int unsigned LINE_W_DEF = 512;
  localparam int unsigned MEM_W_DEF  = 128;
  localparam int unsigned BEATS      = LINE_W_DEF / MEM_W_DEF;
  localparam int unsigned OFFSET_W   = $clog2(LINE_W_DEF / 8);

  localparam logic CL_IC = 1'b0;
  localparam logic CL_DC = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_BEATS,
    S_WR_BEATS,
    S_RESP
  } state_e;

  function automatic int unsigned beats_of(input int unsigned line_w, input int unsigned mem_w);
    return line_w / mem_w;
  endfunction

  function automatic int unsigned offset_w_of(input int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin grant between icache and dcache requesters.
// last_dc remembers who won the most recent accepted handshake; dcache wins the first tie.
module arb_rr2 (
  input  logic clk,
  input  logic reset,
  input  logic ic_req,
  input  logic dc_req,
  input  logic accept,
  output logic grant_ic,
  output logic grant_dc
);

  logic last_dc_q;
  logic last_dc_d;

  always_comb begin
    grant_dc  = dc_req & (~ic_req | ~last_dc_q);
    grant_ic  = ic_req & ~grant_dc;
    last_dc_d = accept ? grant_dc : last_dc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_dc_q <= 1'b0;
    end else begin
      last_dc_q <= last_dc_d;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache line traffic onto one memory port, one transaction at a time.
// Read beats are gathered into a line buffer; dirty lines are serialized out of the same buffer.
module cache_mem_arbiter
  import cache_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned MEM_W  = MEM_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  output logic [LINE_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_req_data,
  output logic              dc_resp_valid,
  output logic [LINE_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [MEM_W-1:0]  mem_req_data,
  input  logic              mem_resp_valid,
  input  logic [MEM_W-1:0]  mem_resp_data,
  output logic              busy,
  output logic              err
);

  localparam int unsigned       NBEATS     = beats_of(LINE_W, MEM_W);
  localparam int unsigned       OFF_W      = offset_w_of(LINE_W);
  localparam int unsigned       CNT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(NBEATS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK   = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(MEM_W / 8);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    nxt;
  logic                cl_q, cl_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
  logic [LINE_W-1:0]   buf_q, buf_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic                mem_req_rw_q, mem_req_rw_d;
  logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
  logic [MEM_W-1:0]    mem_req_data_q, mem_req_data_d;
  logic                ic_resp_valid_q, ic_resp_valid_d;
  logic                dc_resp_valid_q, dc_resp_valid_d;
  logic                err_q, err_d;

  logic idle;
  logic grant_ic;
  logic grant_dc;
  logic accept;

  function automatic int unsigned beat_lsb(input logic [CNT_W-1:0] k);
    return 32'(k) * MEM_W;
  endfunction

  assign idle   = (state_q == S_IDLE);
  // Ready is gated by reset so nothing handshakes while the block is held in reset.
  assign accept = idle & reset & (grant_ic | grant_dc);

  arb_rr2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .ic_req   (ic_req_valid),
    .dc_req   (dc_req_valid),
    .accept   (accept),
    .grant_ic (grant_ic),
    .grant_dc (grant_dc)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    cl_d            = cl_q;
    rw_d            = rw_q;
    line_addr_d     = line_addr_q;
    buf_d           = buf_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_rw_d    = mem_req_rw_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_data_d  = mem_req_data_q;
    ic_resp_valid_d = 1'b0;
    dc_resp_valid_d = 1'b0;
    err_d           = err_q | (mem_resp_valid & (state_q != S_RD_BEATS));
    nxt             = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cl_d            = grant_dc ? CL_DC : CL_IC;
          rw_d            = grant_dc & dc_req_rw;
          line_addr_d     = (grant_dc ? dc_req_addr : ic_req_addr) & ~OFF_MASK;
          cnt_d           = '0;
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = line_addr_d;
          if (rw_d) begin
            buf_d          = dc_req_data;
            mem_req_rw_d   = 1'b1;
            mem_req_data_d = dc_req_data[MEM_W-1:0];
            state_d        = S_WR_BEATS;
          end else begin
            mem_req_rw_d   = 1'b0;
            mem_req_data_d = '0;
            state_d        = S_RD_REQ;
          end
        end
      end

      S_RD_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          mem_req_addr_d  = '0;
          state_d         = S_RD_BEATS;
        end
      end

      S_RD_BEATS: begin
        if (mem_resp_valid) begin
          buf_d[beat_lsb(cnt_q) +: MEM_W] = mem_resp_data;
          cnt_d = nxt;
          if (cnt_q == LAST_BEAT) begin
            cnt_d           = '0;
            ic_resp_valid_d = (cl_q == CL_IC);
            dc_resp_valid_d = (cl_q == CL_DC);
            state_d         = S_RESP;
          end
        end
      end

      S_WR_BEATS: begin
        if (mem_req_ready) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d           = '0;
            mem_req_valid_d = 1'b0;
            mem_req_rw_d    = 1'b0;
            mem_req_addr_d  = '0;
            mem_req_data_d  = '0;
            dc_resp_valid_d = 1'b1;
            state_d         = S_RESP;
          end else begin
            cnt_d          = nxt;
            mem_req_addr_d = line_addr_q + ADDR_W'(nxt) * BEAT_BYTES;
            mem_req_data_d = buf_q[beat_lsb(nxt) +: MEM_W];
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      cl_q            <= CL_IC;
      rw_q            <= 1'b0;
      line_addr_q     <= '0;
      buf_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_rw_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_data_q  <= '0;
      ic_resp_valid_q <= 1'b0;
      dc_resp_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cl_q            <= cl_d;
      rw_q            <= rw_d;
      line_addr_q     <= line_addr_d;
      buf_q           <= buf_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_rw_q    <= mem_req_rw_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_data_q  <= mem_req_data_d;
      ic_resp_valid_q <= ic_resp_valid_d;
      dc_resp_valid_q <= dc_resp_valid_d;
      err_q           <= err_d;
    end
  end

  assign ic_req_ready  = idle & reset & grant_ic;
  assign dc_req_ready  = idle & reset & grant_dc;
  assign ic_resp_valid = ic_resp_valid_q;
  assign dc_resp_valid = dc_resp_valid_q;
  // The buffer still holds the written line after a write, so the write ack data is forced to 0.
  assign ic_resp_data  = ic_resp_valid_q ? buf_q : '0;
  assign dc_resp_data  = (dc_resp_valid_q && !rw_q) ? buf_q : '0;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_rw    = mem_req_rw_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_data  = mem_req_data_q;
  assign busy          = ~idle;
  assign err           = err_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: a transaction-level memory/client model
// with randomized line data, checked against directed scenarios.
module tb_cache_mem_arbiter;
  import cache_mem_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 512;
  localparam int unsigned MW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [AW-1:0] ic_req_addr;
  logic [LW-1:0] ic_resp_data;
  logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_resp_valid;
  logic [AW-1:0] dc_req_addr;
  logic [LW-1:0] dc_req_data, dc_resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_rw, mem_resp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [MW-1:0] mem_req_data, mem_resp_data;
  logic          busy, err;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_W(MW)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .err(err)
  );

  typedef struct { int cyc; logic rw; logic [AW-1:0] addr; logic [MW-1:0] data; } mreq_t;
  typedef struct { logic dc; logic [LW-1:0] data; } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_resp = 0;
  int last_resp_cyc = -1;
  int last_beat_cyc = -1;

  mreq_t         mlog[$];
  exp_t          exp_q[$];
  logic          grants[$];
  int            grant_cyc[$];
  logic [MW-1:0] rd_q[$];

  int            gap_at = -1;
  int            gap_wait = 0;
  bit            toggle_rdy = 0;
  bit            stray = 0;
  bit            ic_new = 0, dc_new = 0;
  logic [AW-1:0] ic_new_addr, dc_new_addr;
  logic          dc_new_rw;
  logic [LW-1:0] dc_new_data;
  bit            ic_cont = 0, dc_cont = 0, ic_stop = 0, dc_stop = 0;
  bit            ic_hs = 0, dc_hs = 0;
  logic          cur_dc = 1'b0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r = '0;
    for (int i = 0; i < LW / 32; i++) r = (r << 32) | LW'($urandom);
    return r;
  endfunction

  // One clock of client + memory behaviour; observes at negedge, drives, then records handshakes.
  task automatic step();
    exp_t          e;
    mreq_t         m;
    logic [MW-1:0] b;
    logic [LW-1:0] line;
    @(negedge clk);
    cyc++;
    if (ic_resp_valid || dc_resp_valid) begin
      chk("resp_one_client", LW'(ic_resp_valid & dc_resp_valid), '0);
      chk("resp_expected", LW'(exp_q.size() > 0), LW'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("resp_client", LW'(dc_resp_valid), LW'(e.dc));
        chk("resp_data", dc_resp_valid ? dc_resp_data : ic_resp_data, e.data);
      end
      last_resp_cyc = cyc;
      n_resp++;
    end

    if (ic_stop || (ic_hs && !ic_cont)) ic_req_valid = 1'b0;
    if (dc_stop || (dc_hs && !dc_cont)) dc_req_valid = 1'b0;
    ic_stop = 0;
    dc_stop = 0;
    if (ic_new) begin
      ic_req_valid = 1'b1; ic_req_addr = ic_new_addr; ic_new = 0;
    end
    if (dc_new) begin
      dc_req_valid = 1'b1; dc_req_addr = dc_new_addr;
      dc_req_rw = dc_new_rw; dc_req_data = dc_new_data; dc_new = 0;
    end
    mem_req_ready  = toggle_rdy ? ~mem_req_ready : 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    if (stray) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      stray = 0;
    end else if (rd_q.size() > 0) begin
      if (int'(BEATS) - rd_q.size() == gap_at && gap_wait > 0) begin
        gap_wait--;
      end else begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = rd_q.pop_front();
        if (rd_q.size() == 0) last_beat_cyc = cyc;
      end
    end

    #1;
    ic_hs = ic_req_valid && ic_req_ready;
    dc_hs = dc_req_valid && dc_req_ready;
    if (ic_hs || dc_hs) begin
      chk("single_grant", LW'(ic_hs & dc_hs), '0);
      cur_dc = dc_hs;
      grants.push_back(dc_hs);
      grant_cyc.push_back(cyc);
      if (dc_hs && dc_req_rw) begin
        e.dc = 1'b1; e.data = '0; exp_q.push_back(e);
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      m.cyc = cyc; m.rw = mem_req_rw; m.addr = mem_req_addr; m.data = mem_req_data;
      mlog.push_back(m);
      if (!mem_req_rw) begin
        line = '0;
        for (int k = 0; k < int'(BEATS); k++) begin
          b = {$urandom, $urandom, $urandom, $urandom};
          rd_q.push_back(b);
          line = line | (LW'(b) << (k * MW));
        end
        e.dc = cur_dc; e.data = line; exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input string tag, input int max);
    bit done = 0;
    for (int n = 0; n < max && !done; n++) begin
      step();
      done = !(exp_q.size() > 0 || busy || ic_req_valid || dc_req_valid || rd_q.size() > 0);
    end
    chk({tag, "_done"}, LW'(done), LW'(1));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ic_req_valid = 1'b0; dc_req_valid = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    ic_new = 0; dc_new = 0; ic_cont = 0; dc_cont = 0; ic_stop = 0; dc_stop = 0;
    ic_hs = 0; dc_hs = 0; stray = 0; gap_at = -1; gap_wait = 0;
    exp_q.delete(); rd_q.delete(); mlog.delete(); grants.delete(); grant_cyc.delete();
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, LW'(busy), '0);
    chk({tag, "_err"}, LW'(err), '0);
    chk({tag, "_mem_valid"}, LW'(mem_req_valid), '0);
    chk({tag, "_mem_rw"}, LW'(mem_req_rw), '0);
    chk({tag, "_mem_addr"}, LW'(mem_req_addr), '0);
    chk({tag, "_mem_data"}, LW'(mem_req_data), '0);
    chk({tag, "_ic_ready"}, LW'(ic_req_ready), '0);
    chk({tag, "_dc_ready"}, LW'(dc_req_ready), '0);
    chk({tag, "_ic_rvalid"}, LW'(ic_resp_valid), '0);
    chk({tag, "_dc_rvalid"}, LW'(dc_resp_valid), '0);
    chk({tag, "_ic_rdata"}, ic_resp_data, '0);
    chk({tag, "_dc_rdata"}, dc_resp_data, '0);
  endtask

  task automatic pad_mlog(input int n);
    mreq_t dm;
    dm.cyc = -1000; dm.rw = 1'bx; dm.addr = 'x; dm.data = 'x;
    while (mlog.size() < n) mlog.push_back(dm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            n0;
    int            r0;
    logic [LW-1:0] wl;
    logic [AW-1:0] a;

    reset = 1'b0;
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_1000;
    dc_req_valid = 1'b1; dc_req_addr = 32'h0000_2000; dc_req_rw = 1'b0; dc_req_data = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    chk("offset_bits", LW'(OFFSET_W), LW'(6));
    do_reset();

    // icache read, zero-wait memory
    r0 = n_resp;
    ic_new = 1; ic_new_addr = 32'h0000_1047;
    wait_done("t1", 40);
    chk("t1_resp_count", LW'(n_resp - r0), LW'(1));
    chk("t1_grant_ic", LW'(grants.size() == 1 && grants[0] == 1'b0), LW'(1));
    n0 = (grant_cyc.size() > 0) ? grant_cyc[0] : -1000;
    chk("t1_mem_count", LW'(mlog.size()), LW'(1));
    pad_mlog(1);
    chk("t1_mem_addr", LW'(mlog[0].addr), LW'(32'h0000_1040));
    chk("t1_mem_rw", LW'(mlog[0].rw), '0);
    chk("t1_mem_cycle", LW'(mlog[0].cyc - n0), LW'(1));
    chk("t1_resp_cycle", LW'(last_resp_cyc - n0), LW'(6));
    chk("t1_idle_cycle", LW'(cyc - n0), LW'(7));
    mlog.delete(); grants.delete(); grant_cyc.delete();

    // dcache write with toggling memory ready
    r0 = n_resp;
    wl = rand_line();
    toggle_rdy = 1; mem_req_ready = 1'b1;
    dc_new = 1; dc_new_addr = 32'h2000_0000; dc_new_rw = 1'b1; dc_new_data = wl;
    wait_done("t2", 60);
    toggle_rdy = 0;
    chk("t2_resp_count", LW'(n_resp - r0), LW'(1));
    chk("t2_beat_count", LW'(mlog.size()), LW'(4));
    pad_mlog(4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_addr%0d", k), LW'(mlog[k].addr), LW'(32'h2000_0000 + 32'(k * 16)));
      chk($sformatf("t2_rw%0d", k), LW'(mlog[k].rw), LW'(1));
      chk($sformatf("t2_data%0d", k), LW'(mlog[k].data), LW'(MW'(wl >> (k * MW))));
    end
    mlog.delete(); grants.delete(); grant_cyc.delete();

    // both clients requesting continuously from reset
    do_reset();
    r0 = n_resp;
    ic_cont = 1; dc_cont = 1;
    ic_new = 1; ic_new_addr = $urandom;
    dc_new = 1; dc_new_addr = $urandom; dc_new_rw = 1'b0; dc_new_data = rand_line();
    for (int n = 0; n < 120 && grants.size() < 4; n++) step();
    chk("t3_four_grants", LW'(grants.size() >= 4), LW'(1));
    ic_cont = 0; dc_cont = 0; ic_stop = 1; dc_stop = 1;
    wait_done("t3", 40);
    while (grants.size() < 4) grants.push_back(1'bx);
    chk("t3_grant0", LW'(grants[0]), LW'(1));
    chk("t3_grant1", LW'(grants[1]), LW'(0));
    chk("t3_grant2", LW'(grants[2]), LW'(1));
    chk("t3_grant3", LW'(grants[3]), LW'(0));
    chk("t3_resp_count", LW'(n_resp - r0), LW'(4));
    mlog.delete(); grants.delete(); grant_cyc.delete();

    // read with two idle cycles between beats 1 and 2
    r0 = n_resp;
    a = $urandom;
    gap_at = 2; gap_wait = 2;
    dc_new = 1; dc_new_addr = a; dc_new_rw = 1'b0;
    wait_done("t4", 40);
    chk("t4_gap_consumed", LW'(gap_wait), '0);
    chk("t4_resp_count", LW'(n_resp - r0), LW'(1));
    chk("t4_resp_after_last", LW'(last_resp_cyc - last_beat_cyc), LW'(1));
    pad_mlog(1);
    chk("t4_mem_addr", LW'(mlog[0].addr), LW'(a & ~32'h3F));
    gap_at = -1;
    mlog.delete(); grants.delete(); grant_cyc.delete();

    // stray response beat while idle
    chk("t5_err_before", LW'(err), '0);
    stray = 1;
    step();
    step();
    chk("t5_err_set", LW'(err), LW'(1));
    r0 = n_resp;
    ic_new = 1; ic_new_addr = $urandom;
    wait_done("t5", 40);
    chk("t5_resp_count", LW'(n_resp - r0), LW'(1));
    chk("t5_err_sticky", LW'(err), LW'(1));
    mlog.delete(); grants.delete(); grant_cyc.delete();

    // reset during beat 2 of a write
    wl = rand_line();
    dc_new = 1; dc_new_addr = 32'h3000_0080; dc_new_rw = 1'b1; dc_new_data = wl;
    for (int n = 0; n < 20 && mlog.size() < 3; n++) step();
    chk("t6_reached_beat2", LW'(mlog.size()), LW'(3));
    reset = 1'b0;
    #1;
    check_reset_outputs("t6_abort");
    do_reset();
    r0 = n_resp;
    repeat (4) step();
    chk("t6_no_resp", LW'(n_resp - r0), '0);
    dc_new = 1; dc_new_addr = 32'h3000_0080; dc_new_rw = 1'b1; dc_new_data = wl;
    wait_done("t6", 40);
    chk("t6_resp_count", LW'(n_resp - r0), LW'(1));
    n0 = (grant_cyc.size() > 0) ? grant_cyc[0] : -1000;
    chk("t6_beat_count", LW'(mlog.size()), LW'(4));
    pad_mlog(4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t6_addr%0d", k), LW'(mlog[k].addr), LW'(32'h3000_0080 + 32'(k * 16)));
      chk($sformatf("t6_data%0d", k), LW'(mlog[k].data), LW'(MW'(wl >> (k * MW))));
      chk($sformatf("t6_cyc%0d", k), LW'(mlog[k].cyc - n0), LW'(k + 1));
    end
    chk("t6_resp_cycle", LW'(last_resp_cyc - n0), LW'(5));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates line-fill and line-write traffic from the instruction cache and data cache onto the single main-memory port. Sits directly downstream of the caches that serve the datapath's `icache_*` and `dcache_*` ports. Converts each line request into a multi-beat memory transaction, with read beats gathered into a line buffer and dirty lines serialized into beats. Only one transaction is in flight at a time.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width.
- `LINE_W`, default 512: cache line width in bits.
- `MEM_W`, default 128: memory beat width in bits. `BEATS = LINE_W/MEM_W`, default 4.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `ic_req_valid`, in, 1: icache line read request.
- `ic_req_ready`, out, 1: icache request accepted when high together with valid.
- `ic_req_addr`, in, ADDR_W: line address; low offset bits ignored.
- `ic_resp_valid`, out, 1: one-cycle pulse, line data valid.
- `ic_resp_data`, out, LINE_W: filled line.
- `dc_req_valid`, in, 1: dcache request.
- `dc_req_ready`, out, 1: dcache handshake.
- `dc_req_rw`, in, 1: 1 means line write, 0 means line read.
- `dc_req_addr`, in, ADDR_W: line address; low offset bits ignored.
- `dc_req_data`, in, LINE_W: write line.
- `dc_resp_valid`, out, 1: one-cycle pulse; read data or write acknowledge.
- `dc_resp_data`, out, LINE_W: read line; 0 on write acknowledge.
- `mem_req_valid`, out, 1: memory request valid.
- `mem_req_ready`, in, 1: memory accepts the request.
- `mem_req_rw`, out, 1: 1 means write beat, 0 means line read.
- `mem_req_addr`, out, ADDR_W: beat-aligned byte address.
- `mem_req_data`, out, MEM_W: write beat.
- `mem_resp_valid`, in, 1: one read beat returned.
- `mem_resp_data`, in, MEM_W: read beat.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `err`, out, 1: sticky flag for a memory response beat received outside RD_BEATS.

## Operation
- FSM states: IDLE, RD_REQ, RD_BEATS, WR_BEATS, RESP.
- Arbitration in IDLE:
  - `*_req_ready` is high only for the granted client, and only in IDLE. Both ready signals are low in every other state.
  - A single requester is granted.
  - If both request, grant goes to the client not served last; a `last_dc` flag is updated on each accept and resets to 0, so dcache wins the first tie.
- Accepting a request latches the client id, `rw`, the line address with the low `log2(LINE_W/8)` bits zeroed, and the write line.
- Read path:
  - RD_REQ holds `mem_req_valid`=1, `rw`=0, `addr` = line address until `mem_req_ready`, then moves to RD_BEATS.
  - RD_BEATS: each `mem_resp_valid` writes `mem_resp_data` into buffer bits `[k*MEM_W +: MEM_W]`, with `k` counting 0..BEATS-1. Beats may have gaps.
  - After beat BEATS-1, go to RESP.
- Write path (dcache only; an icache `rw` does not exist):
  - WR_BEATS presents beat k: `addr` = line address + k*MEM_W/8, `data` = line bits `[k*MEM_W +: MEM_W]`.
  - k advances on each `mem_req_ready`. After beat BEATS-1 is accepted, go to RESP.
- RESP, lasting exactly one cycle:
  - Assert the latched client's `resp_valid`.
  - Data is the buffer for a read, 0 for a write.
  - Return to IDLE.
  - Clients accept responses unconditionally; there is no response back-pressure.
- `mem_resp_valid` in any state other than RD_BEATS is ignored for data and sets `err`. Only reset clears `err`.
- `mem_req_valid` is low in IDLE, RD_BEATS and RESP. All mem request outputs are registered.

## Timing
- Reset values:
  - State IDLE, counters 0, `last_dc`=0, `err`=0, `busy`=0.
  - All valid and ready outputs 0; `*_req_ready` rises combinationally from IDLE once out of reset.
  - All data and address outputs 0.
- Reset mid-transaction aborts immediately. No response is issued, the line buffer is cleared, and the memory system is reset together with this block.
- Read, zero-wait memory (accept at cycle N):
  - `mem_req_valid` in N+1, accepted the same cycle.
  - Beats arrive N+2..N+5.
  - `resp_valid` in N+6; ready again at N+7.
- Write, `mem_req_ready` constantly 1 (accept at N):
  - Beats in N+1..N+4.
  - `dc_resp_valid` in N+5; ready at N+6.
- A request held valid while ready is low keeps its fields stable. Latching happens only on the handshake.

## Structure
- Package `cache_mem_pkg`:
  - State enum.
  - `BEATS` and the `OFFSET_W = log2(LINE_W/8)` constants.
  - Client id constants `CL_IC`/`CL_DC`.
- Sub-module `arb_rr2` holds the 2-way round-robin grant with the `last_dc` register. The FSM, beat counter and line buffer stay in the top level.

## Test plan
- icache read of 0x0000_1047 with zero-wait memory and beats A0..A3 → `mem_req_addr`=0x0000_1040, `ic_resp_data`={A3,A2,A1,A0}, `ic_resp_valid` at N+6.
- dcache write to 0x2000_0000 with line D3..D0 and `mem_req_ready` toggling 1,0,1,… → four beats at 0x2000_0000/10/20/30 carrying D0..D3 in order, followed by one `dc_resp_valid` with data 0.
- Both clients requesting continuously from reset → grants go dc, ic, dc, ic, with no starvation.
- Read with two idle cycles between beats 1 and 2 → correct line assembled, response one cycle after the last beat.
- Stray `mem_resp_valid` in IDLE → `err`=1 and stays set, while the next read completes normally.
- `reset` asserted during beat 2 of a write → all outputs return to reset values, no `dc_resp_valid`, and the next request proceeds from beat 0.
